register_bank: RTL and testbench

- Parametrised successor to the single 4-bit accumulator register of the TTM4 emulator.
- Holds NREG registers of WIDTH bits in one block.
- Each register supports 74HC161/163-style parallel load, synchronous clear and up-count with carry. One selected register drives the shared data bus through an active-low output enable.
- Used for the A/B/OUT registers and the program counter of wider TTM variants.

---
 rtl/ttm_pkg.sv | 16 +
 rtl/register_cell.sv | 35 +++
 rtl/register_bank.sv | 64 ++++++
 tb/tb_register_bank.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttm_pkg.sv
// Shared constants for the TTM register bank: default geometry and the
// conventional register slots used by the emulator datapath.
package ttm_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREG  = 4;
  localparam int DEF_SELW  = 2;

  typedef enum logic [1:0] {
    REG_A   = 2'd0,
    REG_B   = 2'd1,
    REG_OUT = 2'd2,
    REG_PC  = 2'd3
  } reg_idx_e;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register with async reset, sync clear, parallel load and
// up-count with carry (a parametrised 74HC161/163 equivalent).
module register_cell #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             cnt_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             co_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Clear beats load beats count; a load to a counting cell drops the count.
  always_comb begin
    q_d = q_q;
    if (clr_i)      q_d = RST_VAL;
    else if (ld_i)  q_d = d_i;
    else if (cnt_i) q_d = q_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RST_VAL;
    else         q_q <= q_d;
  end

  assign q_o  = q_q;
  assign co_o = cnt_i & (&q_q);

endmodule

// File: rtl/register_bank.sv
// NREG counter/load registers with shared store, count and read ports;
// the selected register drives LOADDATA through an active-low enable.
module register_bank
  import ttm_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               NREG     = DEF_NREG,
  parameter int               SELW     = DEF_SELW,
  parameter int               TRISTATE = 1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  nST,
  input  logic [SELW-1:0]       ST_SEL,
  input  logic [WIDTH-1:0]      STOREDATA,
  input  logic                  CNT_EN,
  input  logic [SELW-1:0]       CNT_SEL,
  input  logic                  nSCLR,
  input  logic                  nOUT,
  input  logic [SELW-1:0]       OUT_SEL,
  output logic [WIDTH-1:0]      LOADDATA,
  output logic                  CO,
  output logic [NREG*WIDTH-1:0] REGS_FLAT
);

  logic [NREG-1:0][WIDTH-1:0] q;
  logic [NREG-1:0]            co_vec;
  logic [WIDTH-1:0]           rd;

  // Only in-range indices decode, so out-of-range selects touch nothing.
  for (genvar i = 0; i < NREG; i++) begin : g_cell
    register_cell #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk_i  (CLK),
      .rst_ni (RST),
      .clr_i  (!nSCLR),
      .ld_i   (!nST && (ST_SEL == SELW'(i))),
      .cnt_i  (CNT_EN && (CNT_SEL == SELW'(i))),
      .d_i    (STOREDATA),
      .q_o    (q[i]),
      .co_o   (co_vec[i])
    );
    assign REGS_FLAT[i*WIDTH +: WIDTH] = q[i];
  end

  // At most one cell sees cnt_i, so OR-ing the carries is the CO mux.
  assign CO = |co_vec;

  always_comb begin
    rd = '0;
    for (int k = 0; k < NREG; k++)
      if (OUT_SEL == SELW'(k)) rd = q[k];
  end

  if (TRISTATE != 0) begin : g_tri
    assign LOADDATA = nOUT ? 'z : rd;
  end else begin : g_zero
    assign LOADDATA = nOUT ? '0 : rd;
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: default build, a 3-register
// zero-bus build and an 8x8 build, checked through expected-value queues.
module tb_register_bank;
  import ttm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT A: WIDTH=4 NREG=4 TRISTATE=1
  logic       a_nst, a_cnt_en, a_nsclr, a_nout;
  logic [1:0] a_stsel, a_cntsel, a_outsel;
  logic [3:0] a_data;
  wire  [3:0] a_ld;
  wire        a_co;
  wire [15:0] a_flat;

  // DUT B: WIDTH=4 NREG=3 TRISTATE=0
  logic       b_nst, b_cnt_en, b_nsclr, b_nout;
  logic [1:0] b_stsel, b_cntsel, b_outsel;
  logic [3:0] b_data;
  wire  [3:0] b_ld;
  wire        b_co;
  wire [11:0] b_flat;

  // DUT C: WIDTH=8 NREG=8 SELW=3
  logic       c_nst, c_cnt_en, c_nsclr, c_nout;
  logic [2:0] c_stsel, c_cntsel, c_outsel;
  logic [7:0] c_data;
  wire  [7:0] c_ld;
  wire        c_co;
  wire [63:0] c_flat;

  register_bank #(.WIDTH(4), .NREG(4), .SELW(2), .TRISTATE(1)) u_a (
    .CLK(clk), .RST(rst_n), .nST(a_nst), .ST_SEL(a_stsel), .STOREDATA(a_data),
    .CNT_EN(a_cnt_en), .CNT_SEL(a_cntsel), .nSCLR(a_nsclr), .nOUT(a_nout),
    .OUT_SEL(a_outsel), .LOADDATA(a_ld), .CO(a_co), .REGS_FLAT(a_flat));

  register_bank #(.WIDTH(4), .NREG(3), .SELW(2), .TRISTATE(0)) u_b (
    .CLK(clk), .RST(rst_n), .nST(b_nst), .ST_SEL(b_stsel), .STOREDATA(b_data),
    .CNT_EN(b_cnt_en), .CNT_SEL(b_cntsel), .nSCLR(b_nsclr), .nOUT(b_nout),
    .OUT_SEL(b_outsel), .LOADDATA(b_ld), .CO(b_co), .REGS_FLAT(b_flat));

  register_bank #(.WIDTH(8), .NREG(8), .SELW(3), .TRISTATE(1)) u_c (
    .CLK(clk), .RST(rst_n), .nST(c_nst), .ST_SEL(c_stsel), .STOREDATA(c_data),
    .CNT_EN(c_cnt_en), .CNT_SEL(c_cntsel), .nSCLR(c_nsclr), .nOUT(c_nout),
    .OUT_SEL(c_outsel), .LOADDATA(c_ld), .CO(c_co), .REGS_FLAT(c_flat));

  logic [3:0]  mdl [4];
  logic [15:0] qa [$];
  logic [11:0] qb [$];
  logic [63:0] qc [$];

  task automatic idle_all();
    a_nst = 1; a_cnt_en = 0; a_nsclr = 1; a_nout = 1;
    a_stsel = 0; a_cntsel = 0; a_outsel = 0; a_data = 0;
    b_nst = 1; b_cnt_en = 0; b_nsclr = 1; b_nout = 1;
    b_stsel = 0; b_cntsel = 0; b_outsel = 0; b_data = 0;
    c_nst = 1; c_cnt_en = 0; c_nsclr = 1; c_nout = 1;
    c_stsel = 0; c_cntsel = 0; c_outsel = 0; c_data = 0;
  endtask

  // Advance DUT A one edge: model predicts, queue holds it, DUT is compared.
  task automatic edge_a(input string name);
    logic [3:0]  nx [4];
    logic [15:0] e, got;
    for (int i = 0; i < 4; i++) begin
      nx[i] = mdl[i];
      if (!a_nsclr)                            nx[i] = 4'h0;
      else if (!a_nst && a_stsel == 2'(i))     nx[i] = a_data;
      else if (a_cnt_en && a_cntsel == 2'(i))  nx[i] = mdl[i] + 4'd1;
    end
    for (int i = 0; i < 4; i++) begin
      mdl[i] = nx[i];
      e[i*4 +: 4] = nx[i];
    end
    qa.push_back(e);
    @(posedge clk); #1;
    got = qa.pop_front();
    checks++;
    if (a_flat !== got) begin
      errors++;
      $display("FAIL %s: REGS_FLAT=%h expected %h", name, a_flat, got);
    end
  endtask

  task automatic edge_b(input string name, input logic [11:0] e);
    logic [11:0] got;
    qb.push_back(e);
    @(posedge clk); #1;
    got = qb.pop_front();
    checks++;
    if (b_flat !== got) begin
      errors++;
      $display("FAIL %s: REGS_FLAT=%h expected %h", name, b_flat, got);
    end
  endtask

  task automatic edge_c(input string name, input logic [63:0] e);
    logic [63:0] got;
    qc.push_back(e);
    @(posedge clk); #1;
    got = qc.pop_front();
    checks++;
    if (c_flat !== got) begin
      errors++;
      $display("FAIL %s: REGS_FLAT=%h expected %h", name, c_flat, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_flat, b_flat, c_flat} !== '0) begin
      errors++;
      $display("FAIL reset_init: flats=%h/%h/%h expected 0", a_flat, b_flat, c_flat);
    end
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 4; i++) mdl[i] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      a_nst = 0; a_stsel = 2'(i); a_data = 4'hA;
      edge_a("reset_preload");
    end
    idle_all();
    a_nout = 0; a_outsel = REG_B;
    #2 rst_n = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 4'h0;
    #1;
    checks++;
    if (a_flat !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: REGS_FLAT=%h expected 0000", a_flat);
    end
    checks++;
    if (a_ld !== 4'h0) begin
      errors++;
      $display("FAIL reset_loaddata: LOADDATA=%h expected 0", a_ld);
    end
    checks++;
    if (a_co !== 1'b0) begin
      errors++;
      $display("FAIL reset_co: CO=%b expected 0", a_co);
    end
    @(negedge clk) rst_n = 1;
    a_nout = 1;
  endtask

  task automatic test_load_read();
    logic [3:0] zz;
    zz = 4'bzzzz;
    a_nst = 0; a_stsel = REG_B; a_data = 4'h5;
    edge_a("load_reg1");
    idle_all();
    a_nout = 0; a_outsel = REG_B;
    #1;
    checks++;
    if (a_ld !== 4'h5) begin
      errors++;
      $display("FAIL read_reg1: LOADDATA=%h expected 5", a_ld);
    end
    a_nst = 0; a_stsel = REG_B; a_data = 4'h6;
    #1;
    checks++;
    if (a_ld !== 4'h5) begin
      errors++;
      $display("FAIL read_before_write: LOADDATA=%h expected 5", a_ld);
    end
    edge_a("write_reg1");
    checks++;
    if (a_ld !== 4'h6) begin
      errors++;
      $display("FAIL read_after_write: LOADDATA=%h expected 6", a_ld);
    end
    idle_all();
    #1;
    checks++;
    if (a_ld !== zz) begin
      errors++;
      $display("FAIL read_disabled: LOADDATA=%b expected zzzz", a_ld);
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] expv [3];
    logic       expc [3];
    expv = '{4'hF, 4'h0, 4'h1};
    expc = '{1'b0, 1'b1, 1'b0};
    a_nst = 0; a_stsel = REG_PC; a_data = 4'hE;
    edge_a("load_reg3");
    idle_all();
    a_cnt_en = 1; a_cntsel = REG_PC;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (a_co !== expc[k]) begin
        errors++;
        $display("FAIL count_co[%0d]: CO=%b expected %b", k, a_co, expc[k]);
      end
      edge_a("count_reg3");
      checks++;
      if (a_flat[15:12] !== expv[k]) begin
        errors++;
        $display("FAIL count_val[%0d]: reg3=%h expected %h", k, a_flat[15:12], expv[k]);
      end
    end
    idle_all();
  endtask

  task automatic test_simultaneous();
    a_nst = 0; a_stsel = REG_A; a_data = 4'h3;   edge_a("sim_pre0");
    a_stsel = REG_OUT; a_data = 4'h7;            edge_a("sim_pre2");
    a_stsel = REG_A; a_data = 4'h9;
    a_cnt_en = 1; a_cntsel = REG_A;
    edge_a("store_beats_count");
    checks++;
    if (a_flat[3:0] !== 4'h9) begin
      errors++;
      $display("FAIL store_beats_count: reg0=%h expected 9", a_flat[3:0]);
    end
    a_data = 4'hC; a_cntsel = REG_OUT;
    edge_a("store_and_count");
    checks++;
    if (a_flat[3:0] !== 4'hC || a_flat[11:8] !== 4'h8) begin
      errors++;
      $display("FAIL store_and_count: reg0=%h reg2=%h expected C and 8", a_flat[3:0], a_flat[11:8]);
    end
    a_nsclr = 0;
    edge_a("sclr_priority");
    checks++;
    if (a_flat !== 16'h0000) begin
      errors++;
      $display("FAIL sclr_priority: REGS_FLAT=%h expected 0000", a_flat);
    end
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic exp_co;
    for (int n = 0; n < 40; n++) begin
      a_nst    = 1'($urandom_range(0, 1));
      a_stsel  = 2'($urandom_range(0, 3));
      a_data   = 4'($urandom_range(0, 15));
      a_cnt_en = 1'($urandom_range(0, 1));
      a_cntsel = 2'($urandom_range(0, 3));
      a_nsclr  = ($urandom_range(0, 15) != 0);
      a_nout   = 0;
      a_outsel = 2'($urandom_range(0, 3));
      #1;
      exp_co = a_cnt_en && (mdl[a_cntsel] == 4'hF);
      checks++;
      if (a_ld !== mdl[a_outsel] || a_co !== exp_co) begin
        errors++;
        $display("FAIL b2b_comb[%0d]: LOADDATA=%h CO=%b expected %h %b", n, a_ld, a_co, mdl[a_outsel], exp_co);
      end
      edge_a("b2b_state");
    end
    idle_all();
  endtask

  task automatic test_out_of_range();
    b_nst = 0;
    b_stsel = 2'd0; b_data = 4'h1; edge_b("oor_pre0", 12'h001);
    b_stsel = 2'd1; b_data = 4'h2; edge_b("oor_pre1", 12'h021);
    b_stsel = 2'd2; b_data = 4'h3; edge_b("oor_pre2", 12'h321);
    b_stsel = 2'd3; b_data = 4'hF; edge_b("oor_store", 12'h321);
    b_nst = 1;
    b_nout = 0; b_outsel = 2'd3;
    b_cnt_en = 1; b_cntsel = 2'd3;
    #1;
    checks++;
    if (b_ld !== 4'h0) begin
      errors++;
      $display("FAIL oor_read: LOADDATA=%h expected 0", b_ld);
    end
    checks++;
    if (b_co !== 1'b0) begin
      errors++;
      $display("FAIL oor_co: CO=%b expected 0", b_co);
    end
    edge_b("oor_count", 12'h321);
    b_cnt_en = 0;
    b_outsel = 2'd2;
    #1;
    checks++;
    if (b_ld !== 4'h3) begin
      errors++;
      $display("FAIL b_read_reg2: LOADDATA=%h expected 3", b_ld);
    end
    b_nout = 1;
    #1;
    checks++;
    if (b_ld !== 4'h0) begin
      errors++;
      $display("FAIL b_read_disabled: LOADDATA=%h expected 0", b_ld);
    end
    idle_all();
  endtask

  task automatic test_width_scaling();
    c_nst = 0;
    c_stsel = 3'd0; c_data = 8'h11; edge_c("w8_pre0", 64'h00000000_00000011);
    c_stsel = 3'd3; c_data = 8'h5A; edge_c("w8_pre3", 64'h00000000_5A000011);
    c_stsel = 3'd7; c_data = 8'hFF; edge_c("w8_pre7", 64'hFF000000_5A000011);
    c_nst = 1;
    c_cnt_en = 1; c_cntsel = 3'd7;
    #1;
    checks++;
    if (c_co !== 1'b1) begin
      errors++;
      $display("FAIL w8_co: CO=%b expected 1", c_co);
    end
    edge_c("w8_wrap", 64'h00000000_5A000011);
    c_cnt_en = 0;
    c_nout = 0; c_outsel = 3'd3;
    #1;
    checks++;
    if (c_ld !== 8'h5A) begin
      errors++;
      $display("FAIL w8_read: LOADDATA=%h expected 5A", c_ld);
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_load_read();
    test_count_wrap();
    test_simultaneous();
    test_back_to_back();
    test_out_of_range();
    test_width_scaling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
